mem_port_arbiter: RTL and testbench

Shares one single-port SP_SRAM between the core's instruction-fetch requester and its load/store requester, so a unified program/data memory can replace the separate I- and D-memories in the RISC-V system. Each cycle it grants at most one requester, drives the SRAM port, and routes the synchronous read data back to the owner one cycle later. A starvation counter bounds fetch latency under continuous data traffic. A saturating conflict counter is exposed for cycle/CPI analysis in the bench.

---
 rtl/riscv_mem_pkg.sv | 14 +
 rtl/arb_starve_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared owner encoding and widths for the unified program/data memory port
package riscv_mem_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  // Who receives the read data returned in the cycle after a grant
  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_IFETCH = 2'd1,
    OWN_DLOAD  = 2'd2
  } owner_e;

endpackage

// File: rtl/arb_starve_counter.sv
// rtl/arb_starve_counter.sv - counts consecutive denied fetch cycles and raises the fetch override
module arb_starve_counter #(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic req_i,
  input  logic gnt_i,
  output logic override_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = 4'd0;
    if (req_i && !gnt_i) begin
      cnt_d = (cnt_q == 4'(STARVE_MAX)) ? cnt_q : cnt_q + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  assign override_o = (cnt_q == 4'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port SRAM between instruction fetch and load/store
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int AWIDTH     = 10,
  parameter int DWIDTH     = DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                I_REQ,
  input  logic [11:0]         I_ADDR,
  output logic                I_GNT,
  output logic                I_RVALID,
  output logic [DWIDTH-1:0]   I_RDATA,
  input  logic                D_REQ,
  input  logic                D_WE,
  input  logic [11:0]         D_ADDR,
  input  logic [DWIDTH/8-1:0] D_BE,
  input  logic [DWIDTH-1:0]   D_WDATA,
  output logic                D_GNT,
  output logic                D_RVALID,
  output logic [DWIDTH-1:0]   D_RDATA,
  output logic                M_CSN,
  output logic                M_WEN,
  output logic [AWIDTH-1:0]   M_ADDR,
  output logic [DWIDTH/8-1:0] M_BE,
  output logic [DWIDTH-1:0]   M_DI,
  input  logic [DWIDTH-1:0]   M_DOUT,
  output logic [31:0]         CONFLICT_CNT
);

  logic   fetch_ovr;
  logic   i_gnt, d_gnt;
  owner_e owner_q, owner_d;
  logic [31:0] conflict_q, conflict_d;

  // Byte-offset bits never reach the word-addressed SRAM
  logic unused_addr_bits;
  assign unused_addr_bits = ^{I_ADDR[1:0], D_ADDR[1:0]};

  arb_starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .req_i      (I_REQ),
    .gnt_i      (i_gnt),
    .override_o (fetch_ovr)
  );

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (RSTn) begin
      i_gnt = I_REQ && (!D_REQ || fetch_ovr);
      d_gnt = D_REQ && !i_gnt;
    end
  end

  always_comb begin
    M_CSN  = 1'b1;
    M_WEN  = 1'b1;
    M_ADDR = '0;
    M_BE   = '0;
    M_DI   = '0;
    if (i_gnt) begin
      M_CSN  = 1'b0;
      M_ADDR = I_ADDR[AWIDTH+1:2];
    end else if (d_gnt) begin
      M_CSN  = 1'b0;
      M_WEN  = !D_WE;
      M_ADDR = D_ADDR[AWIDTH+1:2];
      M_BE   = D_BE;
      if (D_WE) M_DI = D_WDATA;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (i_gnt)               owner_d = OWN_IFETCH;
    else if (d_gnt && !D_WE) owner_d = OWN_DLOAD;
  end

  always_comb begin
    conflict_d = conflict_q;
    if (I_REQ && D_REQ && (conflict_q != 32'hFFFF_FFFF)) conflict_d = conflict_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      owner_q    <= OWN_NONE;
      conflict_q <= 32'd0;
    end else begin
      owner_q    <= owner_d;
      conflict_q <= conflict_d;
    end
  end

  // Read data returned while reset is held belongs to an abandoned access
  assign I_GNT        = i_gnt;
  assign D_GNT        = d_gnt;
  assign I_RVALID     = RSTn && (owner_q == OWN_IFETCH);
  assign D_RVALID     = RSTn && (owner_q == OWN_DLOAD);
  assign I_RDATA      = M_DOUT;
  assign D_RDATA      = M_DOUT;
  assign CONFLICT_CNT = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed table, corner sequences and randomized model check for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int SM = 4;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        I_REQ, I_GNT, I_RVALID;
  logic [11:0] I_ADDR;
  logic [31:0] I_RDATA;
  logic        D_REQ, D_WE, D_GNT, D_RVALID;
  logic [11:0] D_ADDR;
  logic [3:0]  D_BE;
  logic [31:0] D_WDATA, D_RDATA;
  logic        M_CSN, M_WEN;
  logic [9:0]  M_ADDR;
  logic [3:0]  M_BE;
  logic [31:0] M_DI, M_DOUT;
  logic [31:0] CONFLICT_CNT;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.AWIDTH(10), .DWIDTH(32), .STARVE_MAX(SM)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_BE(D_BE), .D_WDATA(D_WDATA),
    .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .M_CSN(M_CSN), .M_WEN(M_WEN), .M_ADDR(M_ADDR), .M_BE(M_BE), .M_DI(M_DI), .M_DOUT(M_DOUT),
    .CONFLICT_CNT(CONFLICT_CNT)
  );

  // Environment SRAM: synchronous read, byte-enabled write
  logic [31:0] sram [1024];
  always @(posedge CLK) begin
    if (!M_CSN) begin
      if (!M_WEN) begin
        for (int b = 0; b < 4; b++) if (M_BE[b]) sram[M_ADDR][8*b +: 8] <= M_DI[8*b +: 8];
      end else begin
        M_DOUT <= sram[M_ADDR];
      end
    end
  end

  // Reference model: memory image, denied-fetch run length, pending response
  logic [31:0]     mem_ref [1024];
  int              deny_run;
  longint unsigned conf;
  int              pend_kind;
  logic [31:0]     pend_data;

  typedef struct {
    logic rstn, ireq, dreq, dwe;
    logic [3:0] dbe;
    logic [31:0] dwd;
    logic eig, edg, ecsn, ewen;
    logic [9:0] eaddr;
    logic [3:0] ebe;
    logic [31:0] edi;
    logic eiv, edv;
    logic [31:0] erd, ecnt;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(logic rstn, logic ireq, logic dreq, logic dwe, logic [3:0] dbe, logic [31:0] dwd,
                              logic eig, logic edg, logic ecsn, logic ewen, logic [9:0] eaddr, logic [3:0] ebe,
                              logic [31:0] edi, logic eiv, logic edv, logic [31:0] erd, logic [31:0] ecnt);
    vec_t v;
    v.rstn = rstn; v.ireq = ireq; v.dreq = dreq; v.dwe = dwe; v.dbe = dbe; v.dwd = dwd;
    v.eig = eig; v.edg = edg; v.ecsn = ecsn; v.ewen = ewen; v.eaddr = eaddr; v.ebe = ebe;
    v.edi = edi; v.eiv = eiv; v.edv = edv; v.erd = erd; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic fw, eig, edg;
    logic [9:0] ea;
    fw  = I_REQ && (!D_REQ || deny_run >= SM);
    eig = RSTn && fw;
    edg = RSTn && D_REQ && !fw;
    ea  = eig ? I_ADDR[11:2] : (edg ? D_ADDR[11:2] : 10'd0);
    chk("m_i_gnt", 64'(I_GNT), 64'(eig));
    chk("m_d_gnt", 64'(D_GNT), 64'(edg));
    chk("m_csn", 64'(M_CSN), 64'(!(eig || edg)));
    chk("m_wen", 64'(M_WEN), 64'(!(edg && D_WE)));
    chk("m_addr", 64'(M_ADDR), 64'(ea));
    chk("m_be", 64'(M_BE), 64'(edg ? D_BE : 4'd0));
    chk("m_di", 64'(M_DI), 64'((edg && D_WE) ? D_WDATA : 32'd0));
    chk("m_i_rvalid", 64'(I_RVALID), 64'(RSTn && pend_kind == 1));
    chk("m_d_rvalid", 64'(D_RVALID), 64'(RSTn && pend_kind == 2));
    if (RSTn && pend_kind == 1) chk("m_i_rdata", 64'(I_RDATA), 64'(pend_data));
    if (RSTn && pend_kind == 2) chk("m_d_rdata", 64'(D_RDATA), 64'(pend_data));
    chk("m_conflict", 64'(CONFLICT_CNT), 64'(conf));
  endtask

  task automatic update_model();
    logic fw, eig, edg;
    fw  = I_REQ && (!D_REQ || deny_run >= SM);
    eig = RSTn && fw;
    edg = RSTn && D_REQ && !fw;
    if (!RSTn) begin
      deny_run = 0; conf = 0; pend_kind = 0;
    end else begin
      if (I_REQ && !eig) deny_run = (deny_run < SM) ? deny_run + 1 : SM;
      else               deny_run = 0;
      if (I_REQ && D_REQ && conf < 64'h0000_0000_FFFF_FFFF) conf++;
      pend_kind = 0;
      if (eig) begin
        pend_kind = 1; pend_data = mem_ref[I_ADDR[11:2]];
      end else if (edg && !D_WE) begin
        pend_kind = 2; pend_data = mem_ref[D_ADDR[11:2]];
      end else if (edg) begin
        for (int b = 0; b < 4; b++) if (D_BE[b]) mem_ref[D_ADDR[11:2]][8*b +: 8] = D_WDATA[8*b +: 8];
      end
    end
  endtask

  task automatic finish_cycle();
    check_model();
    @(posedge CLK);
    update_model();
    #1;
  endtask

  task automatic drive(input logic rstn, input logic ireq, input logic [11:0] ia, input logic dreq,
                       input logic dwe, input logic [11:0] da, input logic [3:0] be, input logic [31:0] wd);
    RSTn = rstn; I_REQ = ireq; I_ADDR = ia; D_REQ = dreq; D_WE = dwe; D_ADDR = da; D_BE = be; D_WDATA = wd;
  endtask

  logic prev_ig, prev_dg;
  logic [31:0] sat_exp [4];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i] = 32'(i) * 32'h9E37_79B9;
      mem_ref[i] = sram[i];
    end
    sram[2] = 32'h0050_0093; mem_ref[2] = 32'h0050_0093;
    sram[4] = 32'h1122_3344; mem_ref[4] = 32'h1122_3344;
    deny_run = 0; conf = 0; pend_kind = 0; pend_data = '0;

    tbl[0]  = mk(0,1,1,0,'hF,0,          0,0,1,1,0,0,0,          0,0,0,0);
    tbl[1]  = mk(1,1,0,0,0,0,            1,0,0,1,2,0,0,          0,0,0,0);
    tbl[2]  = mk(1,0,0,0,0,0,            0,0,1,1,0,0,0,          1,0,'h00500093,0);
    tbl[3]  = mk(1,0,1,1,'h3,'hAABBCCDD, 0,1,0,0,4,'h3,'hAABBCCDD, 0,0,0,0);
    tbl[4]  = mk(1,0,1,0,'hF,0,          0,1,0,1,4,'hF,0,        0,0,0,0);
    tbl[5]  = mk(1,0,0,0,0,0,            0,0,1,1,0,0,0,          0,1,'h1122CCDD,0);
    tbl[6]  = mk(1,1,1,0,'hF,0,          0,1,0,1,4,'hF,0,        0,0,0,0);
    tbl[7]  = mk(1,1,1,0,'hF,0,          0,1,0,1,4,'hF,0,        0,1,'h1122CCDD,1);
    tbl[8]  = mk(1,1,1,0,'hF,0,          0,1,0,1,4,'hF,0,        0,1,'h1122CCDD,2);
    tbl[9]  = mk(1,1,1,0,'hF,0,          0,1,0,1,4,'hF,0,        0,1,'h1122CCDD,3);
    tbl[10] = mk(1,1,1,0,'hF,0,          1,0,0,1,2,0,0,          0,1,'h1122CCDD,4);
    tbl[11] = mk(1,1,1,0,'hF,0,          0,1,0,1,4,'hF,0,        1,0,'h00500093,5);
    tbl[12] = mk(1,1,1,0,'hF,0,          0,1,0,1,4,'hF,0,        0,1,'h1122CCDD,6);
    tbl[13] = mk(1,1,1,0,'hF,0,          0,1,0,1,4,'hF,0,        0,1,'h1122CCDD,7);
    tbl[14] = mk(1,1,1,0,'hF,0,          0,1,0,1,4,'hF,0,        0,1,'h1122CCDD,8);
    tbl[15] = mk(1,1,1,0,'hF,0,          1,0,0,1,2,0,0,          0,1,'h1122CCDD,9);
    tbl[16] = mk(1,0,0,0,0,0,            0,0,1,1,0,0,0,          1,0,'h00500093,10);
    tbl[17] = mk(1,1,1,0,'hF,0,          0,1,0,1,4,'hF,0,        0,0,0,10);
    tbl[18] = mk(1,1,0,0,0,0,            1,0,0,1,2,0,0,          0,1,'h1122CCDD,11);
    tbl[19] = mk(1,0,0,0,0,0,            0,0,1,1,0,0,0,          1,0,'h00500093,11);
    tbl[20] = mk(1,1,1,0,'hF,0,          0,1,0,1,4,'hF,0,        0,0,0,11);
    tbl[21] = mk(1,1,1,0,'hF,0,          0,1,0,1,4,'hF,0,        0,1,'h1122CCDD,12);
    tbl[22] = mk(1,1,1,0,'hF,0,          0,1,0,1,4,'hF,0,        0,1,'h1122CCDD,13);
    tbl[23] = mk(1,1,1,0,'hF,0,          0,1,0,1,4,'hF,0,        0,1,'h1122CCDD,14);
    tbl[24] = mk(1,1,1,0,'hF,0,          1,0,0,1,2,0,0,          0,1,'h1122CCDD,15);
    tbl[25] = mk(1,0,0,0,0,0,            0,0,1,1,0,0,0,          1,0,'h00500093,16);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) begin
      @(posedge CLK);
      update_model();
    end
    #1;

    for (int r = 0; r < 26; r++) begin
      drive(tbl[r].rstn, tbl[r].ireq, 12'h008, tbl[r].dreq, tbl[r].dwe, 12'h010, tbl[r].dbe, tbl[r].dwd);
      #4;
      chk($sformatf("t%0d_i_gnt", r), 64'(I_GNT), 64'(tbl[r].eig));
      chk($sformatf("t%0d_d_gnt", r), 64'(D_GNT), 64'(tbl[r].edg));
      chk($sformatf("t%0d_csn", r), 64'(M_CSN), 64'(tbl[r].ecsn));
      chk($sformatf("t%0d_wen", r), 64'(M_WEN), 64'(tbl[r].ewen));
      chk($sformatf("t%0d_addr", r), 64'(M_ADDR), 64'(tbl[r].eaddr));
      chk($sformatf("t%0d_be", r), 64'(M_BE), 64'(tbl[r].ebe));
      chk($sformatf("t%0d_di", r), 64'(M_DI), 64'(tbl[r].edi));
      chk($sformatf("t%0d_i_rvalid", r), 64'(I_RVALID), 64'(tbl[r].eiv));
      chk($sformatf("t%0d_d_rvalid", r), 64'(D_RVALID), 64'(tbl[r].edv));
      if (tbl[r].eiv) chk($sformatf("t%0d_i_rdata", r), 64'(I_RDATA), 64'(tbl[r].erd));
      if (tbl[r].edv) chk($sformatf("t%0d_d_rdata", r), 64'(D_RDATA), 64'(tbl[r].erd));
      chk($sformatf("t%0d_conflict", r), 64'(CONFLICT_CNT), 64'(tbl[r].ecnt));
      finish_cycle();
    end

    // Reset arriving the cycle after a load grant
    drive(1, 1, 12'h008, 1, 0, 12'h010, 4'hF, 0);
    #4; chk("rst_load_gnt", 64'(D_GNT), 64'd1);
    finish_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #4; chk("rst_no_rvalid", 64'(D_RVALID), 64'd0);
    chk("rst_csn", 64'(M_CSN), 64'd1);
    finish_cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #4; chk("rst_after_rvalid", 64'(D_RVALID), 64'd0);
    chk("rst_after_conflict", 64'(CONFLICT_CNT), 64'd0);
    finish_cycle();
    drive(1, 1, 12'h008, 0, 0, 0, 0, 0);
    #4; chk("rst_fetch_gnt", 64'(I_GNT), 64'd1);
    chk("rst_fetch_addr", 64'(M_ADDR), 64'd2);
    finish_cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #4; chk("rst_fetch_rvalid", 64'(I_RVALID), 64'd1);
    chk("rst_fetch_rdata", 64'(I_RDATA), 64'h0050_0093);
    finish_cycle();

    // Saturation of the conflict counter from a preloaded value
    force dut.conflict_q = 32'hFFFF_FFFD;
    #1;
    release dut.conflict_q;
    conf = 64'h0000_0000_FFFF_FFFD;
    sat_exp[0] = 32'hFFFF_FFFD; sat_exp[1] = 32'hFFFF_FFFE;
    sat_exp[2] = 32'hFFFF_FFFF; sat_exp[3] = 32'hFFFF_FFFF;
    drive(1, 1, 12'h008, 1, 0, 12'h010, 4'hF, 0);
    #3;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) #4;
      chk($sformatf("sat%0d", k), 64'(CONFLICT_CNT), 64'(sat_exp[k]));
      finish_cycle();
    end

    // Randomized traffic against the model, requests held until granted
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #4; finish_cycle();
    prev_ig = 1'b1; prev_dg = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      RSTn = ($urandom_range(0, 199) != 0);
      if (!I_REQ || prev_ig || $urandom_range(0, 15) == 0) begin
        I_REQ  = ($urandom_range(0, 3) != 0);
        I_ADDR = 12'($urandom);
      end
      if (!D_REQ || prev_dg || $urandom_range(0, 15) == 0) begin
        D_REQ   = ($urandom_range(0, 4) != 0);
        D_WE    = $urandom_range(0, 1) == 1;
        D_ADDR  = 12'($urandom);
        D_BE    = 4'($urandom);
        D_WDATA = $urandom;
      end
      #4;
      prev_ig = I_GNT;
      prev_dg = D_GNT;
      finish_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
